// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity,
// one or two stop bits, with back-to-back frames on the final stop bit.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_d, busy_d, done_d;
  logic                  accept;

  // TX_DONE marks the final stop bit, so it doubles as the re-accept window
  assign accept = DATA_VALID &&
                  ((state_q == IDLE) || ((state_q == STOP) && TX_DONE));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = TX_OUT;
    busy_d    = BUSY;
    done_d    = TX_DONE;
    if (accept) begin
      shreg_d   = P_DATA;
      par_en_d  = PAR_EN;
      // parity is fixed at accept time because the word is shifted away
      par_bit_d = (^P_DATA) ^ PAR_TYP;
      stop2_d   = STOP2;
      idx_d     = '0;
      state_d   = START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
        DATA: begin
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
              done_d  = !stop2_q;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
          done_d  = !stop2_q;
        end
        STOP: begin
          if (TX_DONE) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
          end else begin
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      TX_DONE   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      TX_OUT    <= tx_d;
      BUSY      <= busy_d;
      TX_DONE   <= done_d;
    end
  end

endmodule
